// File: rtl/rv32i_pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Mealy stall/flush/redirect outputs over a registered RUN / MEM_WAIT / REDIRECT state.
module rv32i_pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_decode_rs1_addr,
    input  logic [4:0]  i_decode_rs2_addr,
    input  logic        i_decode_rs1_used,
    input  logic        i_decode_rs2_used,
    input  logic [4:0]  i_execute_rd_addr,
    input  logic        i_execute_load,
    input  logic        i_branch_taken,
    input  logic        i_dmem_req,
    input  logic        i_dmem_ack,
    input  logic        i_imem_valid,
    output logic        o_fetch_stall,
    output logic        o_decode_stall,
    output logic        o_decode_flush,
    output logic        o_execute_stall,
    output logic        o_execute_flush,
    output logic        o_memory_stall,
    output logic        o_redirect,
    output logic        o_mem_timeout,
    output logic [31:0] o_stall_count
);
    localparam int unsigned CntWidth = (MEM_TIMEOUT <= 255) ? 8 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMemWait  = 2'd1,
        StRedirect = 2'd2
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [CntWidth-1:0] r_cnt;
    logic [CntWidth-1:0] w_cnt_next;
    logic                r_mem_timeout;
    logic                w_mem_timeout_next;
    logic [31:0]         r_stall_count;
    logic                w_lu;
    logic                w_mm;

    assign w_lu = i_execute_load && (i_execute_rd_addr != 5'd0) &&
                  ((i_decode_rs1_used && (i_decode_rs1_addr == i_execute_rd_addr)) ||
                   (i_decode_rs2_used && (i_decode_rs2_addr == i_execute_rd_addr)));
    assign w_mm = i_dmem_req && !i_dmem_ack;

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_mem_timeout_next = r_mem_timeout;
        o_fetch_stall      = 1'b0;
        o_decode_stall     = 1'b0;
        o_decode_flush     = 1'b0;
        o_execute_stall    = 1'b0;
        o_execute_flush    = 1'b0;
        o_memory_stall     = 1'b0;
        o_redirect         = 1'b0;
        if (reset) begin
            o_decode_flush  = 1'b1;
            o_execute_flush = 1'b1;
        end else begin
            case (r_state)
                StRun: begin
                    if (w_mm) begin
                        {o_fetch_stall, o_decode_stall, o_execute_stall, o_memory_stall} = 4'hF;
                        w_state_next = StMemWait;
                    end else if (i_branch_taken) begin
                        o_redirect      = 1'b1;
                        o_decode_flush  = 1'b1;
                        o_execute_flush = 1'b1;
                        w_state_next    = StRedirect;
                    end else if (w_lu) begin
                        o_fetch_stall   = 1'b1;
                        o_decode_stall  = 1'b1;
                        o_execute_flush = 1'b1;
                    end else if (!i_imem_valid) begin
                        o_fetch_stall  = 1'b1;
                        o_decode_flush = 1'b1;
                    end
                end
                StMemWait: begin
                    if (i_dmem_ack) begin
                        w_cnt_next   = '0;
                        w_state_next = StRun;
                    end else begin
                        {o_fetch_stall, o_decode_stall, o_execute_stall, o_memory_stall} = 4'hF;
                        if (r_cnt != TimeoutVal) begin
                            w_cnt_next = r_cnt + CntWidth'(1);
                        end
                        if (w_cnt_next == TimeoutVal) begin
                            w_mem_timeout_next = 1'b1;
                        end
                    end
                end
                StRedirect: begin
                    // Execute holds a bubble here, so branch and load-use are moot.
                    o_decode_flush = 1'b1;
                    if (w_mm) begin
                        {o_fetch_stall, o_decode_stall, o_execute_stall, o_memory_stall} = 4'hF;
                        w_state_next = StMemWait;
                    end else begin
                        w_state_next = StRun;
                    end
                end
                default: w_state_next = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StRun;
            r_cnt         <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_mem_timeout <= w_mem_timeout_next;
            r_stall_count <= r_stall_count + 32'(o_fetch_stall);
        end
    end

    assign o_mem_timeout = r_mem_timeout;
    assign o_stall_count = r_stall_count;

endmodule

// File: doc/rv32i_pipeline_ctrl.md
# rv32i_pipeline_ctrl

Central hazard and sequencing controller for the 5-stage RV32I pipeline. It watches the decode and execute stages, the execute-stage branch result and the data/instruction memory handshakes. It drives the per-stage stall and flush controls, including `execute_stall` and `execute_flush`, plus the PC redirect strobe. It sits beside the datapath and holds the only pipeline-level state machine.

## Interface
Parameters:
- MEM_TIMEOUT, 255: number of MEM_WAIT cycles after which `mem_timeout` is set.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- decode_rs1_addr  in  5  rs1 index of the instruction in decode.
- decode_rs2_addr  in  5  rs2 index of the instruction in decode.
- decode_rs1_used  in  1  decode instruction reads rs1.
- decode_rs2_used  in  1  decode instruction reads rs2.
- execute_rd_addr  in  5  rd of the instruction held in the execute register.
- execute_load  in  1  instruction in the execute register is a load.
- branch_taken  in  1  registered branch/jump-taken result of the execute stage.
- dmem_req  in  1  memory stage is issuing a data access this cycle.
- dmem_ack  in  1  data memory completes the access this cycle.
- imem_valid  in  1  instruction memory returns a valid word this cycle.
- fetch_stall  out  1  hold the PC and fetch register.
- decode_stall  out  1  hold the decode register.
- decode_flush  out  1  load a bubble into the decode register.
- execute_stall  out  1  hold the execute register.
- execute_flush  out  1  load a bubble into the execute register.
- memory_stall  out  1  hold the memory-stage register.
- redirect  out  1  load the PC from the execute branch target.
- mem_timeout  out  1  sticky data-memory timeout error.
- stall_count  out  32  count of cycles with `fetch_stall` high.

## Operation
- State register values: RUN, MEM_WAIT, REDIRECT. Reset state is RUN.
- The state is registered. All control outputs are Mealy outputs, combinational from the state and the current inputs.
- Load-use hazard, `lu`: `execute_load` AND `execute_rd_addr`≠0 AND ((`decode_rs1_used` AND rs1 matches) OR (`decode_rs2_used` AND rs2 matches)).
- Memory miss, `mm`: `dmem_req` AND NOT `dmem_ack`.

Priority in RUN, highest first:
1. `mm`: assert `fetch_stall`, `decode_stall`, `execute_stall` and `memory_stall`. No flushes. Next state is MEM_WAIT.
2. `branch_taken`: assert `redirect`, `decode_flush` and `execute_flush`. Next state is REDIRECT. A simultaneous `lu` is discarded.
3. `lu`: assert `fetch_stall`, `decode_stall` and `execute_flush`, inserting one bubble. Remain in RUN.
4. NOT `imem_valid`: assert `fetch_stall` and `decode_flush`. Remain in RUN.
5. Otherwise all controls are 0.

MEM_WAIT:
- While NOT `dmem_ack`: all four stall outputs are 1 and the timeout counter increments, saturating at MEM_TIMEOUT.
- When the counter reaches MEM_TIMEOUT: set `mem_timeout`. It is cleared only by reset. The controller stays in MEM_WAIT.
- On `dmem_ack`: all stalls are 0 in that same cycle, the counter is cleared, and the next state is RUN. A `branch_taken` held during the wait is serviced in the following RUN cycle.

REDIRECT:
- Assert `decode_flush` to kill the wrong-path word already in flight from the 1-cycle-latency instruction memory.
- `branch_taken` and `lu` are ignored here, because the execute register holds a bubble.
- If `mm`, apply the MEM_WAIT stall set and go to MEM_WAIT. Otherwise go to RUN.

Counters:
- `stall_count` increments by 1 on every clock with `fetch_stall`=1 and wraps at 2^32.
- The timeout counter is 8 bits wide when MEM_TIMEOUT≤255, otherwise clog2(MEM_TIMEOUT+1) bits.

## Timing
- Reset values: state RUN, `mem_timeout`=0, `stall_count`=0, timeout counter 0.
- While `reset`=1:
  - all stalls and `redirect` are 0;
  - `decode_flush`=`execute_flush`=1.
- Hazard response has zero-cycle latency: a control output is valid in the same cycle as the condition that causes it.
- A load-use costs exactly 1 bubble cycle.
- A taken branch costs exactly 2 flushed slots: the cycle with `branch_taken` plus the REDIRECT cycle.
- A data miss costs N stall cycles, where N is the number of cycles with `dmem_req`=1 and `dmem_ack`=0.
- Reset asserted mid-MEM_WAIT or mid-REDIRECT returns the controller to RUN immediately.

## Test plan
- Load-use: `execute_load`=1, rd=5, decode rs1=5 used → exactly 1 cycle of `fetch_stall`=`decode_stall`=`execute_flush`=1; `stall_count` becomes 1.
- Load to x0: `execute_load`=1, rd=0, decode rs1=0 used → no stall and no flush.
- Taken branch: `branch_taken` high for 1 cycle → `redirect`=1 and both flushes in cycle T; `decode_flush` only in T+1; RUN with all controls 0 in T+2.
- Data miss: `dmem_req`=1 with `dmem_ack` arriving 3 cycles later → 3 cycles of all four stalls, all stalls 0 in the ack cycle, `stall_count`=3.
- Branch under miss: `branch_taken`=1 while in MEM_WAIT → `redirect` only in the cycle after `dmem_ack`.
- Timeout: MEM_TIMEOUT=4, `dmem_ack` held 0 → `mem_timeout`=1 after 4 wait cycles while stalls stay 1; asserting `reset` clears the flag and the state returns to RUN.
